// File: rtl/sha256_pkg.sv
// SHA-256 shared types, round constants and word functions.
// Used by the round controller and the message schedule.
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL
    } state_e;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: 16-word window, W[t] at slot 0.
// Each shift retires W[t] and appends W[t+16].
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] block_in,
    output word_t        w_out
);

    word_t w_q [16];
    word_t w_d [16];

    // Next window contents: load a fresh block or slide by one word
    always_comb begin
        w_d = w_q;
        if (load) begin
            for (int i = 0; i < 16; i++) begin
                w_d[i] = block_in[511-32*i -: 32];
            end
        end else if (shift) begin
            for (int i = 0; i < 15; i++) begin
                w_d[i] = w_q[i+1];
            end
            w_d[15] = small_sigma1(w_q[14]) + w_q[9]
                    + small_sigma0(w_q[1]) + w_q[0];
        end
    end

    // Window register, cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            w_q <= w_d;
        end
    end

    assign w_out = w_q[0];

endmodule

// File: rtl/sha256_round_ctrl.sv
// Iterative SHA-256 compression: one round per clock.
// Owns a..h, the chaining capture, round counter and final add.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = 64,
    parameter int CTR_W      = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [511:0]     block_in,
    input  logic [255:0]     hash_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [255:0]     hash_out,
    output logic [CTR_W-1:0] round_idx
);

    state_e             state_q, state_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic               done_q, done_d;
    logic [255:0]       hout_q, hout_d;
    word_t              v_q [8];
    word_t              v_d [8];
    word_t              hc_q [8];
    word_t              hc_d [8];
    word_t              w_cur;
    word_t              t1, t2;
    logic [5:0]         kidx;
    logic               sch_load, sch_shift;

    assign kidx = 6'(ctr_q);

    sha256_msg_sched u_sched (
        .clk      (clk),
        .rst      (rst),
        .load     (sch_load),
        .shift    (sch_shift),
        .block_in (block_in),
        .w_out    (w_cur)
    );

    // FSM next state, round datapath and final feed-forward add
    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        done_d    = 1'b0;
        hout_d    = hout_q;
        v_d       = v_q;
        hc_d      = hc_q;
        sch_load  = 1'b0;
        sch_shift = 1'b0;
        t1 = v_q[7] + big_sigma1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6])
           + K[kidx] + w_cur;
        t2 = big_sigma0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ROUND;
                    ctr_d    = '0;
                    sch_load = 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        hc_d[i] = hash_in[255-32*i -: 32];
                        v_d[i]  = hash_in[255-32*i -: 32];
                    end
                end
            end
            S_ROUND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    sch_shift = 1'b1;
                    v_d[0] = t1 + t2;
                    v_d[1] = v_q[0];
                    v_d[2] = v_q[1];
                    v_d[3] = v_q[2];
                    v_d[4] = v_q[3] + t1;
                    v_d[5] = v_q[4];
                    v_d[6] = v_q[5];
                    v_d[7] = v_q[6];
                    ctr_d  = ctr_q + 1'b1;
                    if (ctr_q == CTR_W'(NUM_ROUNDS - 1)) begin
                        state_d = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    hout_d[255-32*i -: 32] = hc_q[i] + v_q[i];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter, working and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctr_q   <= '0;
            done_q  <= 1'b0;
            hout_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                v_q[i]  <= '0;
                hc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            done_q  <= done_d;
            hout_q  <= hout_d;
            v_q     <= v_d;
            hc_q    <= hc_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign hash_out  = hout_q;
    assign round_idx = ctr_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: known vectors, reference model,
// scoreboard of expected results and completion cycles.
module tb_sha256_round_ctrl;
    import sha256_pkg::*;

    localparam int NR = 64;
    localparam int CW = 7;

    localparam logic [255:0] IV_C =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_EXP =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_EXP =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [511:0]  block_in = '0;
    logic [255:0]  hash_in = '0;
    logic          ready, busy, done;
    logic [255:0]  hash_out;
    logic [CW-1:0] round_idx;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [255:0] hash;
        int           due;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [511:0] blk;
        logic [255:0] hin;
        logic [255:0] exp;
    } vec_t;

    sha256_round_ctrl #(.NUM_ROUNDS(NR), .CTR_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .block_in  (block_in),
        .hash_in   (hash_in),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .hash_out  (hash_out),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] model(input logic [255:0] hin,
                                           input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  hv [8];
        logic [31:0]  s [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) hv[i] = hin[255-32*i -: 32];
        s = hv;
        for (int t = 0; t < NR; t++) begin
            t1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25))
               + ((s[4] & s[5]) ^ (~s[4] & s[6])) + K[t] + w[t];
            t2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22))
               + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            for (int j = 7; j > 0; j--) s[j] = s[j-1];
            s[4] = s[4] + t1;
            s[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[i] + s[i];
        return r;
    endfunction

    // Scoreboard: every done must match the oldest outstanding job
    always @(negedge clk) begin
        if (!rst && done) begin
            check("done_expected", 256'(sbq.size() != 0), 256'(1));
            if (sbq.size() != 0) begin
                sb_t e;
                e = sbq.pop_front();
                check("hash_out", hash_out, e.hash);
                check("done_latency", 256'(cyc), 256'(e.due));
            end
        end
    end

    task automatic push(input logic [255:0] exp);
        sb_t e;
        e.hash = exp;
        e.due  = cyc + NR + 1;
        sbq.push_back(e);
    endtask

    task automatic launch(input logic [511:0] b, input logic [255:0] h,
                          input bit track, input logic [255:0] exp);
        @(negedge clk);
        block_in = b;
        hash_in  = h;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", 256'(busy), 256'(1));
        if (track) push(exp);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 200);
        check(name, 256'(ready), 256'(1));
    endtask

    task automatic wait_round(input int k, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy && round_idx == CW'(k)) && n < 200);
        check(name, 256'(round_idx), 256'(k));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [3];
        int   n;
        logic [255:0] chain_exp;

        tbl[0] = '{ABC_BLK, IV_C, ABC_EXP};
        tbl[1] = '{EMPTY_BLK, IV_C, EMPTY_EXP};
        tbl[2] = '{512'h0, ABC_EXP, model(ABC_EXP, 512'h0)};
        chain_exp = model(ABC_EXP, 512'h0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 256'(ready), 256'(1));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_hash", hash_out, 256'h0);
        check("rst_round", 256'(round_idx), 256'(0));

        for (int i = 0; i < 3; i++) begin
            launch(tbl[i].blk, tbl[i].hin, 1'b1, tbl[i].exp);
            wait_idle("vec_idle");
        end

        // Back-to-back with chaining; start held high throughout
        @(negedge clk);
        block_in = ABC_BLK;
        hash_in  = IV_C;
        start    = 1'b1;
        @(posedge clk);
        #1;
        push(ABC_EXP);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        check("b2b_done_seen", 256'(done), 256'(1));
        block_in = 512'h0;
        hash_in  = ABC_EXP;
        @(posedge clk);
        #1;
        check("b2b_accept", 256'(busy), 256'(1));
        push(chain_exp);
        @(negedge clk);
        start = 1'b0;
        wait_idle("b2b_idle");

        // Start pulses while busy must not create extra jobs
        launch(EMPTY_BLK, IV_C, 1'b1, EMPTY_EXP);
        wait_round(10, "busy_r10");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_round(40, "busy_r40");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("busy_idle");
        repeat (80) @(negedge clk);

        // Abort at round 20; hash_out keeps the empty-message result
        launch(ABC_BLK, IV_C, 1'b0, 256'h0);
        wait_round(20, "abort_r20");
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", 256'(ready), 256'(1));
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_hash", hash_out, EMPTY_EXP);
        @(negedge clk);
        abort = 1'b0;
        repeat (80) @(negedge clk);
        launch(ABC_BLK, IV_C, 1'b1, ABC_EXP);
        wait_idle("post_abort_idle");

        // Abort in the FINAL cycle is ignored
        launch(EMPTY_BLK, IV_C, 1'b1, EMPTY_EXP);
        wait_round(NR, "final_cycle");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("final_abort_done", 256'(done), 256'(1));
        wait_idle("final_idle");

        // Start and abort together in IDLE: start wins
        @(negedge clk);
        block_in = ABC_BLK;
        hash_in  = IV_C;
        start    = 1'b1;
        abort    = 1'b1;
        @(posedge clk);
        #1;
        check("start_abort_busy", 256'(busy), 256'(1));
        push(ABC_EXP);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        wait_idle("start_abort_idle");

        // Asynchronous reset in the middle of a job
        launch(EMPTY_BLK, IV_C, 1'b0, 256'h0);
        wait_round(30, "rst_r30");
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 256'(ready), 256'(1));
        check("mid_rst_busy", 256'(busy), 256'(0));
        check("mid_rst_done", 256'(done), 256'(0));
        check("mid_rst_hash", hash_out, 256'h0);
        check("mid_rst_round", 256'(round_idx), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        check("sb_drained", 256'(sbq.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
